// File: rtl/fnn_pkg.sv
// Shared types for the final-layer inference sequencer: FSM state encoding and
// the packed-output slicing helper.
package fnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StScan,
        StDone
    } seq_state_t;

    // LSB of neuron i inside the packed layer output bus (each output is 2*data_w wide).
    function automatic int unsigned slice_lsb(input int unsigned i, input int unsigned data_w);
        return 2 * data_w * i;
    endfunction

endpackage

// File: rtl/final_layer_sequencer_argmax_scan.sv
// Sequential argmax over the packed neuron outputs, one neuron per enabled cycle.
// Result outputs already include the neuron examined this cycle.
module argmax_scan
    import fnn_pkg::*;
#(
    parameter int unsigned neuron_number = 10,
    parameter int unsigned dataWidth     = 16,
    parameter int unsigned IDX_W         = $clog2(neuron_number)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_scan_en,
    input  logic                                 i_scan_first,
    input  logic                                 i_scan_last,
    input  logic [IDX_W-1:0]                     i_scan_idx,
    input  logic [2*neuron_number*dataWidth-1:0] i_layer_out,
    output logic [IDX_W-1:0]                     o_idx,
    output logic [2*dataWidth-1:0]               o_score,
    output logic                                 o_valid
);

    localparam int unsigned OUT_W = 2 * dataWidth;

    logic [OUT_W-1:0] w_cand;
    logic             w_take;
    logic [OUT_W-1:0] r_best;
    logic [IDX_W-1:0] r_idx;

    always_comb begin
        w_cand = '0;
        for (int unsigned i = 0; i < neuron_number; i++) begin
            if (i_scan_idx == IDX_W'(i)) begin
                w_cand = i_layer_out[slice_lsb(i, dataWidth) +: OUT_W];
            end
        end
    end

    // Strict greater-than so that ties keep the lower index.
    always_comb begin
        w_take  = i_scan_first | ($signed(w_cand) > $signed(r_best));
        o_idx   = w_take ? i_scan_idx : r_idx;
        o_score = w_take ? w_cand : r_best;
        o_valid = i_scan_en & i_scan_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= '0;
            r_idx  <= '0;
        end else if (i_scan_en) begin
            r_best <= o_score;
            r_idx  <= o_idx;
        end
    end

endmodule

// File: rtl/final_layer_sequencer.sv
// Runs one pass through the final neuron layer: streams activations onto the shared
// input bus, waits out the neuron pipeline, then scans outputs for the winning class.
module final_layer_sequencer
    import fnn_pkg::*;
#(
    parameter int unsigned numWeight     = 784,
    parameter int unsigned neuron_number = 10,
    parameter int unsigned dataWidth     = 16,
    parameter int unsigned PIPE_LAT      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [dataWidth-1:0]                 in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [dataWidth-1:0]                 layer_input,
    output logic                                 layer_freeze,
    output logic                                 layer_clear,
    input  logic [2*neuron_number*dataWidth-1:0] layer_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(neuron_number)-1:0]     class_idx,
    output logic [2*dataWidth-1:0]               class_score
);

    localparam int unsigned OUT_W  = 2 * dataWidth;
    localparam int unsigned IDX_W  = $clog2(neuron_number);
    localparam int unsigned BEAT_W = $clog2(numWeight + 1);
    localparam int unsigned LAT_W  = $clog2(PIPE_LAT + 1);

    seq_state_t         r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [LAT_W-1:0]   r_drain;
    logic [IDX_W-1:0]   r_scan_idx;
    logic               r_in_ready;
    logic [dataWidth-1:0] r_input;
    logic               r_freeze;
    logic               r_clear;
    logic               r_busy;
    logic               r_done;
    logic [IDX_W-1:0]   r_class_idx;
    logic [OUT_W-1:0]   r_class_score;

    logic               w_accept;
    logic               w_scan_en;
    logic               w_scan_first;
    logic               w_scan_last;
    logic [IDX_W-1:0]   w_res_idx;
    logic [OUT_W-1:0]   w_res_score;
    logic               w_res_valid;

    assign w_accept     = in_valid & r_in_ready;
    assign w_scan_en    = (r_state == StScan);
    assign w_scan_first = (r_scan_idx == '0);
    assign w_scan_last  = (r_scan_idx == IDX_W'(neuron_number - 1));

    argmax_scan #(
        .neuron_number (neuron_number),
        .dataWidth     (dataWidth),
        .IDX_W         (IDX_W)
    ) u_argmax_scan (
        .clk          (clk),
        .rst          (rst),
        .i_scan_en    (w_scan_en),
        .i_scan_first (w_scan_first),
        .i_scan_last  (w_scan_last),
        .i_scan_idx   (r_scan_idx),
        .i_layer_out  (layer_out),
        .o_idx        (w_res_idx),
        .o_score      (w_res_score),
        .o_valid      (w_res_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_beat        <= '0;
            r_drain       <= '0;
            r_scan_idx    <= '0;
            r_in_ready    <= 1'b0;
            r_input       <= '0;
            r_freeze      <= 1'b1;
            r_clear       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_class_idx   <= '0;
            r_class_score <= '0;
        end else begin
            r_clear  <= 1'b0;
            r_done   <= 1'b0;
            r_freeze <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_clear <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StClear;
                    end
                end
                StClear: begin
                    r_beat     <= '0;
                    r_in_ready <= 1'b1;
                    r_state    <= StFeed;
                end
                StFeed: begin
                    // Data and un-freeze are registered together so the neurons see both
                    // on the same edge.
                    if (w_accept) begin
                        r_input  <= in_data;
                        r_freeze <= 1'b0;
                        r_beat   <= r_beat + 1'b1;
                        if (r_beat == BEAT_W'(numWeight - 1)) begin
                            r_in_ready <= 1'b0;
                            r_drain    <= '0;
                            r_state    <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (r_drain == LAT_W'(PIPE_LAT - 1)) begin
                        r_scan_idx <= '0;
                        r_state    <= StScan;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                StScan: begin
                    if (w_res_valid) begin
                        r_class_idx   <= w_res_idx;
                        r_class_score <= w_res_score;
                        r_done        <= 1'b1;
                        r_state       <= StDone;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign layer_input  = r_input;
    assign layer_freeze = r_freeze;
    assign layer_clear  = r_clear;
    assign busy         = r_busy;
    assign done         = r_done;
    assign class_idx    = r_class_idx;
    assign class_score  = r_class_score;

endmodule

// File: tb/tb_final_layer_sequencer.sv
// Bench for final_layer_sequencer: table of passes plus reset/start-hold sequences,
// with beat and result scoreboards checked by a negedge monitor.
module tb_final_layer_sequencer;

    localparam int unsigned NW    = 4;
    localparam int unsigned NN    = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned PL    = 2;
    localparam int unsigned OW    = 2 * DW;
    localparam int unsigned IW    = $clog2(NN);
    localparam int          BASE_LAT = 1 + 1 + NW + PL + NN + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        layer_input;
    logic                 layer_freeze;
    logic                 layer_clear;
    logic [NN-1:0][OW-1:0] layer_out;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        class_idx;
    logic [OW-1:0]        class_score;

    always #5 clk = ~clk;

    final_layer_sequencer #(
        .numWeight     (NW),
        .neuron_number (NN),
        .dataWidth     (DW),
        .PIPE_LAT      (PL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .layer_input  (layer_input),
        .layer_freeze (layer_freeze),
        .layer_clear  (layer_clear),
        .layer_out    (layer_out),
        .busy         (busy),
        .done         (done),
        .class_idx    (class_idx),
        .class_score  (class_score)
    );

    typedef struct {
        logic [NW-1:0][DW-1:0] data;
        logic [NN-1:0][OW-1:0] outs;
        bit                    stall;
        bit                    hold_start;
        logic [IW-1:0]         exp_idx;
        logic [OW-1:0]         exp_score;
    } vec_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [OW-1:0] score;
        int            lat;
    } res_t;

    vec_t          vecs[5];
    logic [DW-1:0] beat_q[$];
    res_t          res_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int freeze_low_cnt = 0;
    int clear_cnt = 0;
    int done_cnt  = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: consumes expected beats on un-frozen cycles and expected results on done.
    initial begin
        logic [DW-1:0] prev_in;
        logic [DW-1:0] exp_b;
        res_t          r;
        prev_in = '0;
        forever begin
            @(negedge clk);
            if (layer_clear) clear_cnt++;
            if (!layer_freeze) begin
                freeze_low_cnt++;
                check(beat_q.size() != 0, "beat_expected", beat_q.size(), 1);
                if (beat_q.size() != 0) begin
                    exp_b = beat_q.pop_front();
                    check(layer_input == exp_b, "layer_input", layer_input, exp_b);
                end
            end else if (in_ready) begin
                check(layer_input == prev_in, "input_hold", layer_input, prev_in);
            end
            prev_in = layer_input;
            if (done) begin
                done_cnt++;
                check(res_q.size() != 0, "done_expected", res_q.size(), 1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    check(class_idx == r.idx, "class_idx", class_idx, r.idx);
                    check(class_score == r.score, "class_score",
                          longint'($signed(class_score)), longint'($signed(r.score)));
                    check(cyc - start_cyc + 1 == r.lat, "done_latency",
                          cyc - start_cyc + 1, r.lat);
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check(in_ready == 1'b1, "in_ready_wait", in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int clr0;
        int dn0;
        layer_out = v.outs;
        clr0 = clear_cnt;
        dn0  = done_cnt;
        freeze_low_cnt = 0;
        res_q.push_back('{idx: v.exp_idx, score: v.exp_score,
                          lat: BASE_LAT + (v.stall ? int'(NW) - 1 : 0)});
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        if (!v.hold_start) start = 1'b0;
        check(busy == 1'b1, "busy_in_pass", busy, 1);
        wait_ready();
        for (int b = 0; b < int'(NW); b++) begin
            if (v.stall && b > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = v.data[b];
            beat_q.push_back(v.data[b]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check(in_ready == 1'b0, "in_ready_drop", in_ready, 0);
        k = 0;
        while (!done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check(done == 1'b1, "done_seen", done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(done_cnt - dn0 == 1, "done_count", done_cnt - dn0, 1);
        check(clear_cnt - clr0 == 1, "clear_count", clear_cnt - clr0, 1);
        check(freeze_low_cnt == int'(NW), "freeze_low_count", freeze_low_cnt, NW);
        check(busy == 1'b0, "busy_after", busy, 0);
        check(class_idx == v.exp_idx, "result_hold", class_idx, v.exp_idx);
    endtask

    initial begin
        logic [54:0] idle_exp;
        logic [54:0] idle_act;
        int          dn0;

        vecs[0] = '{data: {16'd4, 16'd3, 16'd2, 16'd1},
                    outs: {32'sd7, 32'sd20, -32'sd5},
                    stall: 1'b0, hold_start: 1'b0, exp_idx: 2'd1, exp_score: 32'sd20};
        vecs[1] = '{data: {16'd8, 16'd7, 16'd6, 16'd5},
                    outs: {-32'sd9, -32'sd3, -32'sd3},
                    stall: 1'b1, hold_start: 1'b0, exp_idx: 2'd0, exp_score: -32'sd3};
        vecs[2] = '{data: {16'hffff, 16'h8000, 16'h0001, 16'h1234},
                    outs: {-32'sd3, -32'sd3, -32'sd9},
                    stall: 1'b0, hold_start: 1'b0, exp_idx: 2'd1, exp_score: -32'sd3};
        vecs[3] = '{data: {16'd40, 16'd30, 16'd20, 16'd10},
                    outs: {32'sd100, -32'sd200, 32'sd100},
                    stall: 1'b1, hold_start: 1'b1, exp_idx: 2'd0, exp_score: 32'sd100};
        vecs[4] = '{data: {16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d},
                    outs: {32'h8000_0000, 32'h8000_0001, 32'h8000_0000},
                    stall: 1'b0, hold_start: 1'b1, exp_idx: 2'd1, exp_score: 32'h8000_0001};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; layer_out = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // {busy, done, in_ready, layer_freeze, layer_clear, layer_input, class_idx, class_score}
        idle_exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            idle_act = {busy, done, in_ready, layer_freeze, layer_clear, layer_input,
                        class_idx, class_score};
            check(idle_act == idle_exp, "reset_idle", idle_act, idle_exp);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset two beats into FEED: abort to idle, no done, then a clean pass.
        dn0 = done_cnt;
        layer_out = vecs[1].outs;
        res_q.push_back('{idx: vecs[1].exp_idx, score: vecs[1].exp_score, lat: BASE_LAT});
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready();
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_data  = vecs[1].data[b];
            beat_q.push_back(vecs[1].data[b]);
            @(posedge clk); #1;
        end
        in_data = vecs[1].data[2];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        res_q.delete();
        idle_act = {busy, done, in_ready, layer_freeze, layer_clear, layer_input,
                    class_idx, class_score};
        check(idle_act == idle_exp, "mid_reset_values", idle_act, idle_exp);
        repeat (20) @(posedge clk);
        #1;
        check(done_cnt == dn0, "mid_reset_no_done", done_cnt - dn0, 0);
        check(busy == 1'b0, "mid_reset_idle", busy, 0);
        run_vec(vecs[0]);

        check(beat_q.size() == 0, "beat_queue_empty", beat_q.size(), 0);
        check(res_q.size() == 0, "result_queue_empty", res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
